// File: rtl/mem_arb_pkg.sv
// Shared encodings for the CPU/DMA RAM arbiter: FSM states, owner codes
// and byte-lane constants.
package mem_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_C_ISSUE,
    ST_C_DONE,
    ST_D_ISSUE,
    ST_D_DONE
  } arb_state_t;

  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_CPU  = 2'b01;
  localparam logic [1:0] OWN_DMA  = 2'b10;

  localparam logic [1:0] BE_NONE = 2'b00;
  localparam logic [1:0] BE_LO   = 2'b01;
  localparam logic [1:0] BE_HI   = 2'b10;
  localparam logic [1:0] BE_WORD = 2'b11;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner selection: CPU has priority unless DMA has been
// passed over STARVE times in a row.
module mem_arb_pick
  import mem_arb_pkg::*;
#(
  parameter int unsigned STARVE = 4
) (
  input  logic       cpu_req,
  input  logic       dma_req,
  input  logic [3:0] starve_cnt,
  output logic       grant_cpu,
  output logic       grant_dma
);

  always_comb begin
    grant_cpu = 1'b0;
    grant_dma = 1'b0;
    if (cpu_req && dma_req) begin
      if (starve_cnt == 4'(STARVE)) grant_dma = 1'b1;
      else                          grant_cpu = 1'b1;
    end else if (cpu_req) begin
      grant_cpu = 1'b1;
    end else if (dma_req) begin
      grant_dma = 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between the CPU memory interface and a DMA port.
// One access per ISSUE/DONE pair; read data is forwarded during the ack cycle.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned AW     = 16,
  parameter int unsigned DW     = 16,
  parameter int unsigned STARVE = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic          cpu_be,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_ack,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_wait,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wdata,
  output logic          dma_ack,
  output logic [DW-1:0] dma_rdata,
  output logic          ram_en,
  output logic          ram_we,
  output logic [1:0]    ram_be,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata,
  output logic [1:0]    owner
);

  arb_state_t    state, state_nxt;
  logic [3:0]    starve_cnt;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic          we_q;
  logic [1:0]    be_q;
  logic [DW-1:0] cpu_hold, dma_hold;
  logic          grant_cpu, grant_dma;
  logic          decide;

  mem_arb_pick #(.STARVE(STARVE)) u_pick (
    .cpu_req   (cpu_req),
    .dma_req   (dma_req),
    .starve_cnt(starve_cnt),
    .grant_cpu (grant_cpu),
    .grant_dma (grant_dma)
  );

  assign decide    = (state == ST_IDLE) || (state == ST_C_DONE) || (state == ST_D_DONE);
  assign cpu_wait  = cpu_req & ~cpu_ack;
  assign ram_addr  = addr_q;
  assign ram_wdata = wdata_q;
  assign ram_be    = be_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      starve_cnt <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      be_q       <= BE_NONE;
      cpu_hold   <= '0;
      dma_hold   <= '0;
    end else begin
      state <= state_nxt;
      if (decide) begin
        if (!dma_req || grant_dma)
          starve_cnt <= '0;
        else if (grant_cpu && starve_cnt != 4'(STARVE))
          starve_cnt <= starve_cnt + 4'd1;

        if (grant_cpu) begin
          addr_q  <= cpu_addr;
          wdata_q <= cpu_wdata;
          we_q    <= cpu_we;
          // Reads and word writes use both lanes; byte writes pick by addr[0].
          if (cpu_we && cpu_be) be_q <= cpu_addr[0] ? BE_HI : BE_LO;
          else                  be_q <= BE_WORD;
        end else if (grant_dma) begin
          addr_q  <= dma_addr;
          wdata_q <= dma_wdata;
          we_q    <= dma_we;
          be_q    <= BE_WORD;
        end
      end
      if (state == ST_C_DONE && !we_q) cpu_hold <= ram_rdata;
      if (state == ST_D_DONE && !we_q) dma_hold <= ram_rdata;
    end
  end

  always_comb begin
    state_nxt = state;
    ram_en    = 1'b0;
    cpu_ack   = 1'b0;
    dma_ack   = 1'b0;
    owner     = OWN_NONE;
    cpu_rdata = cpu_hold;
    dma_rdata = dma_hold;
    case (state)
      ST_IDLE, ST_C_DONE, ST_D_DONE: begin
        if (grant_cpu)      state_nxt = ST_C_ISSUE;
        else if (grant_dma) state_nxt = ST_D_ISSUE;
        else                state_nxt = ST_IDLE;
        if (state == ST_C_DONE) begin
          cpu_ack = 1'b1;
          owner   = OWN_CPU;
          if (!we_q) cpu_rdata = ram_rdata;
        end
        if (state == ST_D_DONE) begin
          dma_ack = 1'b1;
          owner   = OWN_DMA;
          if (!we_q) dma_rdata = ram_rdata;
        end
      end
      ST_C_ISSUE: begin
        state_nxt = ST_C_DONE;
        ram_en    = 1'b1;
        owner     = OWN_CPU;
      end
      ST_D_ISSUE: begin
        state_nxt = ST_D_DONE;
        ram_en    = 1'b1;
        owner     = OWN_DMA;
      end
      default: state_nxt = ST_IDLE;
    endcase
    ram_we = ram_en & we_q;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port RAM arbiter that shares the main memory between the CPU memory interface (MAR/MDR/IR traffic sequenced by the microcoded decoder) and a DMA requester. It runs a small access state machine that issues one RAM access at a time, returns read data with a one-cycle ack, and raises `cpu_wait` so the decoder FSM can stall. A starvation counter prevents CPU priority from locking out DMA.

## Interface
- `AW`, 16, address width (word address)
- `DW`, 16, data width
- `STARVE`, 4, consecutive CPU grants allowed while DMA is pending before DMA is forced; legal range 1..15

- `clk` in 1: system clock; all state changes on rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `cpu_req` in 1: CPU access request; held with addr/data/we/be stable until `cpu_ack`.
- `cpu_we` in 1: 1 = write, 0 = read.
- `cpu_be` in 1: 1 = byte write, 0 = word.
- `cpu_addr` in AW: CPU address.
- `cpu_wdata` in DW: CPU write data.
- `cpu_ack` out 1: one-cycle pulse; access complete.
- `cpu_rdata` out DW: read data, valid while `cpu_ack`=1.
- `cpu_wait` out 1: `cpu_req & ~cpu_ack`, combinational; stalls the decoder.
- `dma_req`, `dma_we`, `dma_addr`, `dma_wdata` in 1/1/AW/DW: DMA port, same rules; word access only.
- `dma_ack` out 1, `dma_rdata` out DW: as CPU.
- `ram_en`, `ram_we` out 1: RAM strobe and write enable.
- `ram_be` out 2: byte lanes; bit 0 = low byte.
- `ram_addr` out AW, `ram_wdata` out DW: to RAM.
- `ram_rdata` in DW: synchronous RAM output, valid the cycle after `ram_en`.
- `owner` out 2: 00 none, 01 CPU, 10 DMA; current access owner.

## Operation
- States: IDLE, C_ISSUE, C_DONE, D_ISSUE, D_DONE.
- A decision is made in IDLE and in each *_DONE state:
  - Neither requesting: IDLE.
  - Only one requesting: that requester's ISSUE.
  - Both requesting: CPU wins unless `starve_cnt == STARVE`, in which case DMA wins.
- A requester whose ack is being asserted in the current *_DONE state counts as requesting only if its `req` is still high. Back-to-back accesses are allowed.
- ISSUE: `ram_en`=1. `ram_addr`, `ram_we` and `ram_wdata` come from the owner, registered at entry.
- DONE: `ram_en`=0 and the owner's ack is 1. Read data is passed from `ram_rdata` to the owner's rdata, which holds its value until the next ack. A write also acks in DONE.
- `ram_be`:
  - DMA and CPU word accesses: 11.
  - CPU byte access: `cpu_addr[0]`=0 gives 01, 1 gives 10.
  - Reads always drive 11.
- `starve_cnt` (4 bit):
  - +1 on each CPU grant while `dma_req`=1, saturating at STARVE.
  - Cleared on any DMA grant, and whenever `dma_req`=0 at a decision point.
- `owner` = 01 in C_*, 10 in D_*, 00 in IDLE.

## Timing
- Reset (async assert, synchronous release):
  - state IDLE
  - `starve_cnt`=0
  - `ram_en`, `ram_we`, `cpu_ack`, `dma_ack` = 0
  - `ram_be`=00, addr/wdata/rdata = 0, `owner`=00
- Reset asserted mid-access aborts the access immediately: no ack, `ram_en` drops asynchronously.
- Latency from IDLE: req seen at edge N, ISSUE during cycle N+1, ack during N+2. Peak throughput is one access per 2 cycles.
- `cpu_wait` is high from the first req cycle until the ack cycle and low during the ack cycle.
- A requester that drops `req` before ack is a protocol violation. Behaviour is undefined, but the FSM must still return to IDLE within 2 cycles.
- Simultaneous first requests from IDLE with `starve_cnt`=0: CPU granted.

## Structure
- Package `mem_arb_pkg` holds the state encoding, the owner codes (OWN_NONE/CPU/DMA) and the `ram_be` lane constants.
- One sub-module, `mem_arb_pick`: combinational winner selection from `cpu_req`, `dma_req`, `starve_cnt` and STARVE. The FSM, counter and muxes stay in `mem_arbiter`.

## Test plan
- **CPU read:** RAM[0x0010]=0xBEEF, `cpu_req` read at 0x0010. Expect `ram_en` for 1 cycle, `cpu_ack` 2 cycles after req with `cpu_rdata`=0xBEEF, and `cpu_wait` high for exactly 2 cycles.
- **CPU byte write:** addr 0x0021, data 0x00AB, `cpu_be`=1. Expect `ram_be`=10 and `ram_we`=1. A readback of 0x0021 returns the high byte changed and the low byte intact.
- **Contention / starvation (STARVE=4):** CPU and DMA both request continuously. Expect grant order C,C,C,C,D,C,C,C,C,D, with `starve_cnt` cleared on each D.
- **DMA alone:** 8 back-to-back writes to 0x0100..0x0107. Expect 8 `dma_ack` pulses 2 cycles apart, `owner`=10 throughout, and RAM contents verified.
- **Reset mid-access:** `reset` low during C_ISSUE. Expect `ram_en`=0 immediately, no `cpu_ack`, all outputs at reset values. After release, a new request completes normally.
- **Halted CPU:** `cpu_req` held 0 with DMA active. Expect `cpu_wait`=0 and `starve_cnt` remaining 0.
